// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: forwarding selects, load-use and multiplier-scoreboard stalls, PC-write flushes.
// Latency: all hazard outputs are combinational (0 cycles); scoreboard entries load on the issuing edge.
// Backpressure: StallF/StallD hold fetch/decode, FlushD/FlushE insert bubbles; no internal buffering.
//
// Ports:
//   clk, rst (async, active-low)
//   RA_D/RAvalid_D, WA_D, RegWriteD, MulOpD      : decode-stage sources, destination, multiply flag
//   RA_E, WA_E, RegWriteE, MemtoRegE             : execute-stage sources, destination, load flag
//   WA_M/RegWriteM, WA_W/RegWriteW               : later-stage writers used for forwarding
//   PCSrcD/E/M/W, BranchTakenE                   : PC-write / branch indications
//   ForwardE (2 bits per port: 10=M, 01=W, 00=RF), ldrStallD, sbStallD, StallF, StallD,
//   FlushD, FlushE, PCWrPendingF, StallCnt, FlushCnt
// Optional feature macro: HAZ_PERF_CNT_EN (saturating stall/flush counters; tied to 0 when undefined).
module hazard_ctrl_sb #(
  parameter int NREGS         = 16,
  parameter int NRP           = 3,
  parameter int MUL_LAT       = 4,
  parameter int MUL_PIPELINED = 0,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(MUL_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP*AW-1:0] RA_D,
  input  logic [NRP-1:0]    RAvalid_D,
  input  logic [AW-1:0]     WA_D,
  input  logic [AW-1:0]     WA_E,
  input  logic [AW-1:0]     WA_M,
  input  logic [AW-1:0]     WA_W,
  input  logic              RegWriteD,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MulOpD,
  input  logic              MemtoRegE,
  input  logic [NRP*AW-1:0] RA_E,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  output logic [2*NRP-1:0]  ForwardE,
  output logic              ldrStallD,
  output logic              sbStallD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              PCWrPendingF,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  // Per-register countdown to multiply writeback; nonzero means result not yet available.
  logic [CW-1:0]    r_cnt [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_ld_match;
  logic             w_raw;
  logic             w_waw;
  logic             w_struct;
  logic             w_issue;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // Forwarding: M stage has priority over W stage.
  always_comb begin
    ForwardE = '0;
    for (int p = 0; p < NRP; p++) begin
      if (RegWriteM && (RA_E[p*AW +: AW] == WA_M)) begin
        ForwardE[2*p +: 2] = 2'b10;
      end else if (RegWriteW && (RA_E[p*AW +: AW] == WA_W)) begin
        ForwardE[2*p +: 2] = 2'b01;
      end
    end
  end

  // Load-use: a load in execute feeding any valid decode source.
  always_comb begin
    w_ld_match = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      if (RAvalid_D[p] && (RA_D[p*AW +: AW] == WA_E)) begin
        w_ld_match = 1'b1;
      end
    end
  end

  assign ldrStallD = MemtoRegE & RegWriteE & w_ld_match;

  // Scoreboard lookups written as a scan over registers so a non-power-of-two
  // NREGS never indexes past the counter array.
  always_comb begin
    w_raw = 1'b0;
    w_waw = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (w_busy[r]) begin
        for (int p = 0; p < NRP; p++) begin
          if (RAvalid_D[p] && (RA_D[p*AW +: AW] == AW'(r))) begin
            w_raw = 1'b1;
          end
        end
        if (RegWriteD && (WA_D == AW'(r))) begin
          w_waw = 1'b1;
        end
      end
    end
  end

  // A non-pipelined multiplier holds only one op, so any live entry blocks a new multiply.
  assign w_struct = (MUL_PIPELINED == 0) && MulOpD && (|w_busy);

  assign sbStallD     = w_raw | w_waw | w_struct;
  assign PCWrPendingF = PCSrcD | PCSrcE | PCSrcM;
  assign StallD       = ldrStallD | sbStallD;
  assign StallF       = StallD | PCWrPendingF;
  assign FlushE       = StallD | BranchTakenE;
  assign FlushD       = PCWrPendingF | PCSrcW | BranchTakenE;

  // FlushD gates issue so a killed decode slot never leaves a stale entry.
  assign w_issue = MulOpD & RegWriteD & ~StallD & ~FlushD;

  // Load beats decrement; decrement only from nonzero so counters never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_issue && (WA_D == AW'(r))) begin
          r_cnt[r] <= CW'(MUL_LAT);
        end else if (w_busy[r]) begin
          r_cnt[r] <= r_cnt[r] - CW'(1);
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (FlushD && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: directed + random bench for hazard_ctrl_sb against a cycle-time reference model.
// The model tracks, per register, the first cycle in which a multiply result is usable.
// Outputs are sampled mid-cycle (falling edge or shortly after input changes).
module tb_hazard_ctrl_sb;
  localparam int NREGS   = 16;
  localparam int NRP     = 3;
  localparam int MUL_LAT = 4;
  localparam int PIPE    = 0;
  localparam int AW      = $clog2(NREGS);

  logic              clk = 1'b0;
  logic              rst;
  logic [NRP*AW-1:0] RA_D, RA_E;
  logic [NRP-1:0]    RAvalid_D;
  logic [AW-1:0]     WA_D, WA_E, WA_M, WA_W;
  logic              RegWriteD, RegWriteE, RegWriteM, RegWriteW;
  logic              MulOpD, MemtoRegE;
  logic              PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [2*NRP-1:0]  ForwardE;
  logic              ldrStallD, sbStallD, StallF, StallD, FlushD, FlushE, PCWrPendingF;
  logic [31:0]       StallCnt, FlushCnt;

  hazard_ctrl_sb #(
    .NREGS(NREGS), .NRP(NRP), .MUL_LAT(MUL_LAT), .MUL_PIPELINED(PIPE)
  ) dut (
    .clk(clk), .rst(rst),
    .RA_D(RA_D), .RAvalid_D(RAvalid_D),
    .WA_D(WA_D), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
    .RegWriteD(RegWriteD), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MulOpD(MulOpD), .MemtoRegE(MemtoRegE), .RA_E(RA_E),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .ForwardE(ForwardE), .ldrStallD(ldrStallD), .sbStallD(sbStallD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCWrPendingF(PCWrPendingF), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  longint      cyc   = 0;
  longint      free_at [NREGS];
  logic [31:0] m_scnt, m_fcnt;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] s0;
`endif

  logic [2*NRP-1:0] e_fwd;
  logic e_ldr, e_sb, e_sf, e_sd, e_fd, e_fe, e_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input logic [AW-1:0] r);
    return cyc < free_at[r];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) free_at[r] = 0;
    m_scnt = '0;
    m_fcnt = '0;
  endtask

  task automatic model_eval();
    bit any;
    e_fwd = '0;
    for (int p = 0; p < NRP; p++) begin
      if (RegWriteM && RA_E[p*AW +: AW] == WA_M)      e_fwd[2*p +: 2] = 2'b10;
      else if (RegWriteW && RA_E[p*AW +: AW] == WA_W) e_fwd[2*p +: 2] = 2'b01;
    end
    e_ldr = 1'b0;
    if (MemtoRegE && RegWriteE)
      for (int p = 0; p < NRP; p++)
        if (RAvalid_D[p] && RA_D[p*AW +: AW] == WA_E) e_ldr = 1'b1;
    any = 0;
    for (int r = 0; r < NREGS; r++) if (busy(AW'(r))) any = 1;
    e_sb = 1'b0;
    for (int p = 0; p < NRP; p++)
      if (RAvalid_D[p] && busy(RA_D[p*AW +: AW])) e_sb = 1'b1;
    if (RegWriteD && busy(WA_D)) e_sb = 1'b1;
    if (PIPE == 0 && MulOpD && any) e_sb = 1'b1;
    e_pc = PCSrcD | PCSrcE | PCSrcM;
    e_sd = e_ldr | e_sb;
    e_sf = e_sd | e_pc;
    e_fe = e_sd | BranchTakenE;
    e_fd = e_pc | PCSrcW | BranchTakenE;
  endtask

  task automatic check_all(input string tag);
    model_eval();
    chk({tag, ":fwd"},   32'(ForwardE),     32'(e_fwd));
    chk({tag, ":ldr"},   32'(ldrStallD),    32'(e_ldr));
    chk({tag, ":sb"},    32'(sbStallD),     32'(e_sb));
    chk({tag, ":stlD"},  32'(StallD),       32'(e_sd));
    chk({tag, ":stlF"},  32'(StallF),       32'(e_sf));
    chk({tag, ":flD"},   32'(FlushD),       32'(e_fd));
    chk({tag, ":flE"},   32'(FlushE),       32'(e_fe));
    chk({tag, ":pcwr"},  32'(PCWrPendingF), 32'(e_pc));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ":scnt"},  StallCnt, m_scnt);
    chk({tag, ":fcnt"},  FlushCnt, m_fcnt);
`else
    chk({tag, ":scnt"},  StallCnt, 32'd0);
    chk({tag, ":fcnt"},  FlushCnt, 32'd0);
`endif
  endtask

  // One cycle: check at the falling edge, advance the model at the rising edge,
  // return 1 time unit after it ready for the next drive.
  task automatic adv(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (rst) begin
      if (MulOpD && RegWriteD && !e_sd && !e_fd) free_at[WA_D] = cyc + MUL_LAT + 1;
      if (e_sd && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
      if (e_fd && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    RA_D = '0; RA_E = '0; RAvalid_D = '0;
    WA_D = '0; WA_E = '0; WA_M = '0; WA_W = '0;
    RegWriteD = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MulOpD = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
  endtask

  task automatic set_rd(input int p, input int r, input logic v);
    RA_D[p*AW +: AW] = AW'(r);
    RAvalid_D[p] = v;
  endtask

  task automatic issue_mul(input int r);
    idle();
    MulOpD = 1; RegWriteD = 1; WA_D = AW'(r);
  endtask

  function automatic logic [AW-1:0] rreg();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Forwarding priority
    idle();
    RA_E[0 +: AW] = AW'(3); WA_M = AW'(3); RegWriteM = 1; WA_W = AW'(3); RegWriteW = 1;
    #3 chk("fwd_m", 32'(ForwardE[1:0]), 32'd2);
    adv("fwd_m");
    RegWriteM = 0;
    #3 chk("fwd_w", 32'(ForwardE[1:0]), 32'd1);
    adv("fwd_w");
    RegWriteW = 0;
    #3 chk("fwd_rf", 32'(ForwardE[1:0]), 32'd0);
    adv("fwd_rf");

    // Load-use
    idle();
    MemtoRegE = 1; RegWriteE = 1; WA_E = AW'(5); set_rd(1, 5, 1'b1);
    #3 chk("ldr", 32'({ldrStallD, StallD, StallF, FlushE}), 32'hF);
    adv("ldr");
    RAvalid_D[1] = 1'b0;
    #3 chk("ldr_off", 32'({ldrStallD, StallD, StallF, FlushE}), 32'h0);
    adv("ldr_off");

    // RAW on multiply result: exactly MUL_LAT stall cycles
    issue_mul(7);
    adv("mul_r7");
`ifdef HAZ_PERF_CNT_EN
    s0 = m_scnt;
`endif
    idle();
    set_rd(0, 7, 1'b1);
    for (int i = 0; i < MUL_LAT; i++) begin
      #3 chk("raw_stall", 32'(sbStallD), 32'd1);
      adv("raw_stall");
    end
    #3 chk("raw_release", 32'(sbStallD), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("raw_scnt", StallCnt, s0 + 32'd4);
`endif
    adv("raw_release");

    // Structural stall on the single-op multiplier
    issue_mul(2);
    adv("mul_r2");
    issue_mul(4);
    for (int i = 0; i < MUL_LAT; i++) begin
      #3 chk("struct_stall", 32'(sbStallD), 32'd1);
      adv("struct_stall");
    end
    #3 chk("struct_release", 32'(sbStallD), 32'd0);
    adv("struct_release");
    idle();
    repeat (MUL_LAT + 1) adv("drain");

    // Branch kills a multiply in decode
    issue_mul(9);
    BranchTakenE = 1;
    #3 chk("br_flushD", 32'(FlushD), 32'd1);
    adv("br_kill");
    idle();
    set_rd(2, 9, 1'b1); RegWriteD = 1; WA_D = AW'(9);
    #3 chk("br_no_entry", 32'(sbStallD), 32'd0);
    adv("br_no_entry");
    idle();
    PCSrcE = 1;
    #3 chk("pcsrcE", 32'({PCWrPendingF, StallF, FlushD}), 32'h7);
    adv("pcsrcE");

    // Reset in the middle of a pending multiply
    issue_mul(1);
    adv("mul_r1");
    idle();
    set_rd(0, 1, 1'b1);
    adv("r1_wait");
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_sb", 32'(sbStallD), 32'd0);
    chk("rst_scnt", StallCnt, 32'd0);
    chk("rst_fcnt", FlushCnt, 32'd0);
    adv("rst_hold");
    rst = 1'b1;
    adv("rst_after");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        model_reset();
        #1 check_all("rnd_rst");
        adv("rnd_rst_hold");
        rst = 1'b1;
      end else begin
        for (int p = 0; p < NRP; p++) begin
          RA_D[p*AW +: AW] = rreg();
          RA_E[p*AW +: AW] = rreg();
        end
        RAvalid_D    = NRP'($urandom);
        WA_D = rreg(); WA_E = rreg(); WA_M = rreg(); WA_W = rreg();
        RegWriteD    = ($urandom_range(0, 1) == 0);
        RegWriteE    = ($urandom_range(0, 1) == 0);
        RegWriteM    = ($urandom_range(0, 1) == 0);
        RegWriteW    = ($urandom_range(0, 1) == 0);
        MulOpD       = ($urandom_range(0, 2) == 0);
        MemtoRegE    = ($urandom_range(0, 3) == 0);
        PCSrcD       = ($urandom_range(0, 9) == 0);
        PCSrcE       = ($urandom_range(0, 9) == 0);
        PCSrcM       = ($urandom_range(0, 9) == 0);
        PCSrcW       = ($urandom_range(0, 9) == 0);
        BranchTakenE = ($urandom_range(0, 9) == 0);
        adv("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
